// File: rtl/asynchronous_fifo_core_if.sv
// Push/pop bundle for the FIFO core: writer-side request/data plus reader-side show-ahead data and status flags.
interface asynchronous_fifo_core_if #(
    parameter int FIFO_DATAWIDTH = 16
);
    // Handshake: a write is accepted at a clock edge iff wr_en=1 and full=0;
    // a pop is accepted iff rd_en=1 and empty=0. dout is the head word whenever
    // empty=0, so the consumer samples it before the edge on which it asserts rd_en.
    logic                      wr_en;
    logic [FIFO_DATAWIDTH-1:0] din;
    logic                      full;
    logic                      rd_en;
    logic [FIFO_DATAWIDTH-1:0] dout;
    logic                      empty;

    modport master (
        output wr_en,
        output din,
        output rd_en,
        input  full,
        input  dout,
        input  empty
    );

    modport slave (
        input  wr_en,
        input  din,
        input  rd_en,
        output full,
        output dout,
        output empty
    );
endinterface

// File: rtl/asynchronous_fifo_core.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers; rd_clk kept only for pin compatibility.
module asynchronous_fifo_core #(
    parameter int FIFO_ADDRWIDTH = 3,
    parameter int FIFO_DATAWIDTH = 16
) (
    input  logic                     wr_clk,
    input  logic                     rd_clk,
    input  logic                     rst,
    asynchronous_fifo_core_if.slave  fifo
);
    localparam int DEPTH = 1 << FIFO_ADDRWIDTH;
    localparam logic [FIFO_ADDRWIDTH:0] PTR_ONE = {{FIFO_ADDRWIDTH{1'b0}}, 1'b1};

    logic [FIFO_DATAWIDTH-1:0] mem [DEPTH];
    logic [FIFO_ADDRWIDTH:0]   wr_add;
    logic [FIFO_ADDRWIDTH:0]   rd_add;
    logic                      full_int;
    logic                      empty_int;
    logic                      do_write;
    logic                      do_read;
    logic                      unused_rd_clk;

    assign unused_rd_clk = rd_clk;

    // Equal pointers mean empty; same slot but opposite wrap bit means full.
    assign empty_int = (wr_add == rd_add);
    assign full_int  = (wr_add[FIFO_ADDRWIDTH-1:0] == rd_add[FIFO_ADDRWIDTH-1:0]) &&
                       (wr_add[FIFO_ADDRWIDTH] != rd_add[FIFO_ADDRWIDTH]);

    assign do_write = fifo.wr_en && !full_int;
    assign do_read  = fifo.rd_en && !empty_int;

    assign fifo.full  = full_int;
    assign fifo.empty = empty_int;
    assign fifo.dout  = mem[rd_add[FIFO_ADDRWIDTH-1:0]];

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_add <= '0;
            rd_add <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_add[FIFO_ADDRWIDTH-1:0]] <= fifo.din;
                wr_add <= wr_add + PTR_ONE;
            end
            if (do_read) begin
                rd_add <= rd_add + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_asynchronous_fifo_core.sv
// Randomized bench for asynchronous_fifo_core against a queue-based FIFO reference model.
module tb_asynchronous_fifo_core;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic wr_clk;
    logic rd_clk;
    logic rst;

    logic [DW-1:0] exp_q[$];
    int checks;
    int errors;

    asynchronous_fifo_core_if #(.FIFO_DATAWIDTH(DW)) fifo_if ();

    asynchronous_fifo_core #(
        .FIFO_ADDRWIDTH(AW),
        .FIFO_DATAWIDTH(DW)
    ) dut (
        .wr_clk (wr_clk),
        .rd_clk (rd_clk),
        .rst    (rst),
        .fifo   (fifo_if.slave)
    );

    // clock / reset
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end
    assign rd_clk = wr_clk;

    // driver: inputs change on the falling edge, away from the active edge
    task automatic drive(input bit r, input bit we, input bit re, input logic [DW-1:0] d);
        @(negedge wr_clk);
        rst           = r;
        fifo_if.wr_en = we;
        fifo_if.rd_en = re;
        fifo_if.din   = d;
    endtask

    // one rising edge, with the reference queue advanced from its pre-edge occupancy
    task automatic tick();
        bit do_w;
        bit do_r;
        do_w = fifo_if.wr_en && (exp_q.size() < DEPTH);
        do_r = fifo_if.rd_en && (exp_q.size() > 0);
        @(posedge wr_clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (do_r) void'(exp_q.pop_front());
            if (do_w) exp_q.push_back(fifo_if.din);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (fifo_if.empty !== 1'b1 || fifo_if.full !== 1'b0 || fifo_if.dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: empty=%b full=%b dout=%h, expected empty=1 full=0 dout=0000",
                     fifo_if.empty, fifo_if.full, fifo_if.dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 1'b0, 16'($urandom));
                tick();
            end
            drive(1'b0, 1'b1, 1'b0, 16'($urandom));
            tick();
            checks++;
            if (fifo_if.empty !== 1'b0 || fifo_if.full !== (exp_q.size() == DEPTH) ||
                fifo_if.dout !== exp_q[0]) begin
                errors++;
                $display("FAIL fill_%0d: empty=%b full=%b dout=%h, expected empty=0 full=%b dout=%h",
                         i, fifo_if.empty, fifo_if.full, fifo_if.dout, exp_q.size() == DEPTH, exp_q[0]);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 16'hBEEF);
        tick();
        checks++;
        if (fifo_if.full !== 1'b1 || fifo_if.empty !== 1'b0 || exp_q.size() != DEPTH) begin
            errors++;
            $display("FAIL fill_overflow: full=%b empty=%b model_size=%0d, expected full=1 empty=0 size=%0d",
                     fifo_if.full, fifo_if.empty, exp_q.size(), DEPTH);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] held;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'($urandom));
            checks++;
            if (fifo_if.dout !== exp_q[0]) begin
                errors++;
                $display("FAIL drain_data_%0d: dout=%h, expected %h", i, fifo_if.dout, exp_q[0]);
            end
            tick();
            checks++;
            if (fifo_if.empty !== (exp_q.size() == 0) || fifo_if.full !== 1'b0) begin
                errors++;
                $display("FAIL drain_flags_%0d: empty=%b full=%b, expected empty=%b full=0",
                         i, fifo_if.empty, fifo_if.full, exp_q.size() == 0);
            end
        end
        held = fifo_if.dout;
        drive(1'b0, 1'b0, 1'b1, 16'($urandom));
        tick();
        checks++;
        if (fifo_if.empty !== 1'b1 || fifo_if.dout !== held) begin
            errors++;
            $display("FAIL drain_underflow: empty=%b dout=%h, expected empty=1 dout=%h",
                     fifo_if.empty, fifo_if.dout, held);
        end
    endtask

    task automatic test_interleave();
        int w_left;
        int r_left;
        int cyc;
        bit we;
        bit re;
        w_left = 20;
        r_left = 20;
        cyc    = 0;
        while ((w_left > 0 || r_left > 0) && cyc < 2000) begin
            we = (w_left > 0) && ($urandom_range(0, 2) != 0);
            re = (r_left > 0) && ($urandom_range(0, 2) != 0);
            drive(1'b0, we, re, 16'($urandom));
            if (re && exp_q.size() > 0) begin
                checks++;
                if (fifo_if.dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL interleave_data: cycle %0d dout=%h, expected %h", cyc, fifo_if.dout, exp_q[0]);
                end
                r_left--;
            end
            if (we && exp_q.size() < DEPTH) w_left--;
            tick();
            checks++;
            if (fifo_if.empty !== (exp_q.size() == 0) || fifo_if.full !== (exp_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL interleave_flags: cycle %0d empty=%b full=%b, expected empty=%b full=%b",
                         cyc, fifo_if.empty, fifo_if.full, exp_q.size() == 0, exp_q.size() == DEPTH);
            end
            cyc++;
        end
        if (w_left > 0 || r_left > 0) begin
            checks++;
            errors++;
            $display("FAIL interleave_timeout: writes_left=%0d reads_left=%0d, expected 0 and 0", w_left, r_left);
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'($urandom));
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 16'($urandom));
        checks++;
        if (fifo_if.full !== 1'b1 || fifo_if.dout !== exp_q[0]) begin
            errors++;
            $display("FAIL boundary_full_pre: full=%b dout=%h, expected full=1 dout=%h",
                     fifo_if.full, fifo_if.dout, exp_q[0]);
        end
        tick();
        checks++;
        if (fifo_if.full !== 1'b0 || fifo_if.empty !== 1'b0 || fifo_if.dout !== exp_q[0]) begin
            errors++;
            $display("FAIL boundary_full_rw: full=%b empty=%b dout=%h, expected full=0 empty=0 dout=%h",
                     fifo_if.full, fifo_if.empty, fifo_if.dout, exp_q[0]);
        end
        while (exp_q.size() > 0) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (fifo_if.dout !== exp_q[0]) begin
                errors++;
                $display("FAIL boundary_drain: dout=%h, expected %h", fifo_if.dout, exp_q[0]);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 16'h1234);
        tick();
        checks++;
        if (fifo_if.empty !== 1'b0 || fifo_if.dout !== 16'h1234 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL boundary_empty_rw: empty=%b dout=%h model_size=%0d, expected empty=0 dout=1234 size=1",
                     fifo_if.empty, fifo_if.dout, exp_q.size());
        end
        drive(1'b0, 1'b0, 1'b1, '0);
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'($urandom_range(1, 16'hFFFF)));
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 16'h5A5A);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (fifo_if.empty !== 1'b1 || fifo_if.full !== 1'b0 || fifo_if.dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: empty=%b full=%b dout=%h, expected empty=1 full=0 dout=0000",
                     fifo_if.empty, fifo_if.full, fifo_if.dout);
        end
        drive(1'b0, 1'b1, 1'b0, 16'hA5A5);
        tick();
        drive(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (fifo_if.empty !== 1'b0 || fifo_if.dout !== 16'hA5A5) begin
            errors++;
            $display("FAIL reset_mid_write: empty=%b dout=%h, expected empty=0 dout=a5a5",
                     fifo_if.empty, fifo_if.dout);
        end
        tick();
        checks++;
        if (fifo_if.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_read: empty=%b, expected 1", fifo_if.empty);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        fifo_if.wr_en = 1'b0;
        fifo_if.rd_en = 1'b0;
        fifo_if.din   = '0;
        test_reset();
        test_fill();
        test_drain();
        test_interleave();
        test_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
